// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment constants, decode table and scan states.
// Segments are active-low, packed as {a,b,c,d,e,f,g} = seg[6:0].
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bit position of each segment inside seg[6:0].
    typedef enum logic [2:0] {
        SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A
    } seg_bit_t;

    // Active-low glyphs, entry n = hex digit n.
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h38, 7'h30, 7'h42, 7'h31,
        7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C,
        7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic {
        ST_GUARD,
        ST_DRIVE
    } scan_state_t;

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational hex nibble to active-low 7-segment glyph.
// One instance is shared by all digits of the scan controller.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TAB[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed scan of an NDIG-digit common-anode display.
// New values enter a one-slot pending buffer and go live at frame ends.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG    = 8,
    parameter int DWELL   = 1000,
    parameter int GUARD   = 2,
    parameter int LZ_SUPP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [4*NDIG-1:0] upd_data,
    input  logic [NDIG-1:0]   upd_dp,
    input  logic              blank_en,
    output logic [NDIG-1:0]   dig_sel,
    output logic [6:0]        seg,
    output logic              seg_dp,
    output logic              frame_tick
);

    localparam int CW = $clog2(DWELL);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] ONE_HOT = {{(NDIG-1){1'b0}}, 1'b1};

    logic [CW-1:0]        dwell_cnt;
    logic [IW-1:0]        idx;
    scan_state_t          state;
    scan_state_t          state_nxt;
    logic [NDIG-1:0][3:0] act_data;
    logic [NDIG-1:0][3:0] pend_data;
    logic [NDIG-1:0]      act_dp;
    logic [NDIG-1:0]      pend_dp;
    logic                 pend_full;
    logic                 dwell_wrap;
    logic                 boundary;
    logic                 xfer;
    logic                 upper_zero;
    logic [NDIG-1:0]      supp;
    logic [3:0]           cur_nib;
    logic [6:0]           cur_seg;
    logic [NDIG-1:0]      dig_sel_nxt;
    logic [6:0]           seg_nxt;
    logic                 seg_dp_nxt;

    assign dwell_wrap = (dwell_cnt == CNT_LAST);
    assign boundary   = dwell_wrap && (idx == IDX_LAST);
    assign upd_ready  = !pend_full;
    assign xfer       = upd_valid && upd_ready;
    assign cur_nib    = act_data[idx];

    hex7seg_dec u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // Dwell counter and digit index; idx steps once per dwell wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            idx       <= '0;
        end else if (dwell_wrap) begin
            dwell_cnt <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
        end
    end

    // Pending slot fills on handshake, drains into active at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else if (boundary && pend_full) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            pend_full <= 1'b0;
        end else if (xfer) begin
            pend_data <= upd_data;
            pend_dp   <= upd_dp;
            pend_full <= 1'b1;
        end
    end

    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        supp       = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_data[i] == 4'h0);
            supp[i]    = (LZ_SUPP != 0) && (i != 0) && upper_zero;
        end
    end

    // Guard/drive state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_GUARD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output values for the selected digit.
    always_comb begin
        state_nxt   = state;
        dig_sel_nxt = '1;
        seg_nxt     = SEG_OFF;
        seg_dp_nxt  = 1'b1;
        unique case (state)
            ST_GUARD: begin
                if (dwell_cnt == GUARD_END) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (dwell_wrap) state_nxt = ST_GUARD;
                if (!blank_en) dig_sel_nxt = ~(ONE_HOT << idx);
                seg_nxt    = supp[idx] ? SEG_OFF : cur_seg;
                seg_dp_nxt = !act_dp[idx];
            end
        endcase
    end

    // Registered pin drivers; reset forces the display dark at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel    <= '1;
            seg        <= SEG_OFF;
            seg_dp     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            dig_sel    <= dig_sel_nxt;
            seg        <= seg_nxt;
            seg_dp     <= seg_dp_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench with a frame-level reference model.
// Two DUTs share stimulus: one with and one without zero suppression.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int GD = 2;
    localparam int FR = ND * DW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic        blank_en;
    logic        upd_ready, upd_ready_nl;
    logic [3:0]  dig_sel, dig_sel_nl;
    logic [6:0]  seg, seg_nl;
    logic        seg_dp, seg_dp_nl;
    logic        frame_tick, frame_tick_nl;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    logic [6:0] tab [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    int   k;
    logic m_full;
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_p, m_pend_p;
    logic [3:0]  e_dig;
    logic [6:0]  e_seg1, e_seg0;
    logic        e_dp, e_tick;

    int         cnt [4];
    int         dpc [4];
    logic [6:0] s1 [4];
    logic [6:0] s0 [4];
    int         stray;

    seg_scan_ctrl #(
        .NDIG(ND), .DWELL(DW), .GUARD(GD), .LZ_SUPP(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .blank_en   (blank_en),
        .dig_sel    (dig_sel),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .frame_tick (frame_tick)
    );

    seg_scan_ctrl #(
        .NDIG(ND), .DWELL(DW), .GUARD(GD), .LZ_SUPP(0)
    ) dut_nl (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready_nl),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .blank_en   (blank_en),
        .dig_sel    (dig_sel_nl),
        .seg        (seg_nl),
        .seg_dp     (seg_dp_nl),
        .frame_tick (frame_tick_nl)
    );

    always #5 clk = ~clk;

    function automatic int didx(input int t);
        return (t % FR) / DW;
    endfunction

    function automatic bit drv(input int t);
        return (t % DW) >= GD;
    endfunction

    function automatic logic [6:0] exp_seg(
        input logic [15:0] d, input int i, input bit lz
    );
        logic [15:0] up;
        up = d >> (4 * i);
        if (lz && i > 0 && up == 16'h0) return 7'h7F;
        return tab[up[3:0]];
    endfunction

    // Reference: edge t shows the digit selected by the counters at t.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= 0;
            m_full   <= 1'b0;
            m_act_d  <= '0;
            m_act_p  <= '0;
            m_pend_d <= '0;
            m_pend_p <= '0;
            e_dig    <= 4'hF;
            e_seg1   <= 7'h7F;
            e_seg0   <= 7'h7F;
            e_dp     <= 1'b1;
            e_tick   <= 1'b0;
        end else begin
            e_tick <= (k % FR) == FR - 1;
            e_dig  <= (drv(k) && !blank_en)
                      ? ~(4'b0001 << didx(k)) : 4'hF;
            e_seg1 <= drv(k) ? exp_seg(m_act_d, didx(k), 1'b1) : 7'h7F;
            e_seg0 <= drv(k) ? exp_seg(m_act_d, didx(k), 1'b0) : 7'h7F;
            e_dp   <= drv(k) ? !m_act_p[didx(k)] : 1'b1;
            if ((k % FR) == FR - 1 && m_full) begin
                m_act_d <= m_pend_d;
                m_act_p <= m_pend_p;
                m_full  <= 1'b0;
            end else if (upd_valid && !m_full) begin
                m_pend_d <= upd_data;
                m_pend_p <= upd_dp;
                m_full   <= 1'b1;
            end
            k <= k + 1;
        end
    end

    task automatic chk(
        input string name, input logic [31:0] act, input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("dig_sel", 32'(dig_sel), 32'(e_dig));
                chk("seg", 32'(seg), 32'(e_seg1));
                chk("seg_dp", 32'(seg_dp), 32'(e_dp));
                chk("tick", 32'(frame_tick), 32'(e_tick));
                chk("ready", 32'(upd_ready), 32'(!m_full));
                chk("nl_dig_sel", 32'(dig_sel_nl), 32'(e_dig));
                chk("nl_seg", 32'(seg_nl), 32'(e_seg0));
                chk("nl_seg_dp", 32'(seg_dp_nl), 32'(e_dp));
                chk("nl_tick", 32'(frame_tick_nl), 32'(e_tick));
                chk("nl_ready", 32'(upd_ready_nl), 32'(!m_full));
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] p);
        int n;
        n = 0;
        @(posedge clk);
        #2;
        upd_valid = 1'b1;
        upd_data  = d;
        upd_dp    = p;
        @(negedge clk);
        while (!upd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(upd_ready), 32'h1);
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("tick_seen", 32'(frame_tick), 32'h1);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < ND; i++) begin
            cnt[i] = 0;
            dpc[i] = 0;
            s1[i]  = 7'h55;
            s0[i]  = 7'h55;
        end
        stray = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                if (dig_sel == ~(4'b0001 << i)) begin
                    cnt[i]++;
                    s1[i] = seg;
                    s0[i] = seg_nl;
                    if (!seg_dp) dpc[i]++;
                end
            end
            if (dig_sel == 4'hF && !seg_dp) stray++;
        end
    endtask

    task automatic chk_segs(
        input string tag, input logic [27:0] e1, input logic [27:0] e0
    );
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s_seg%0d", tag, i),
                32'(s1[i]), 32'(e1[7*i +: 7]));
            chk($sformatf("%s_nlseg%0d", tag, i),
                32'(s0[i]), 32'(e0[7*i +: 7]));
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        upd_dp    = '0;
        blank_en  = 1'b0;
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dig", 32'(dig_sel), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(seg_dp), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_ready", 32'(upd_ready), 32'h1);
        chk_on = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;

        send(16'h1234, 4'h0);
        wait_tick();
        capture(FR);
        chk_segs("t1", {7'h4F, 7'h12, 7'h06, 7'h4C},
                       {7'h4F, 7'h12, 7'h06, 7'h4C});
        for (int i = 0; i < ND; i++)
            chk($sformatf("t1_on%0d", i), 32'(cnt[i]), 32'd6);
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        chk("tick_period", 32'(n), 32'd32);

        send(16'h0070, 4'h0);
        wait_tick();
        capture(FR);
        chk_segs("t2", {7'h7F, 7'h7F, 7'h0F, 7'h01},
                       {7'h01, 7'h01, 7'h0F, 7'h01});

        send(16'h5678, 4'h1);
        @(negedge clk);
        chk("t3_stall", 32'(upd_ready), 32'h0);
        send(16'h9ABC, 4'h0);
        capture(30);
        chk_segs("t3a", {7'h24, 7'h20, 7'h0F, 7'h00},
                        {7'h24, 7'h20, 7'h0F, 7'h00});
        chk("t3a_dp0", 32'(dpc[0]), 32'd6);
        wait_tick();
        capture(FR);
        chk_segs("t3b", {7'h04, 7'h08, 7'h60, 7'h31},
                        {7'h04, 7'h08, 7'h60, 7'h31});

        wait_tick();
        send(16'h2468, 4'h0);
        repeat (29) @(posedge clk);
        #2;
        upd_valid = 1'b1;
        upd_data  = 16'h1357;
        upd_dp    = 4'h0;
        @(negedge clk);
        chk("t4_bnd_full", 32'(upd_ready), 32'h0);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t4_ready_back", 32'(upd_ready), 32'h1);
        @(posedge clk);
        #2 upd_valid = 1'b0;
        @(negedge clk);
        chk("t4_held", 32'(upd_ready), 32'h0);
        capture(28);
        chk_segs("t4a", {7'h12, 7'h4C, 7'h20, 7'h00},
                        {7'h12, 7'h4C, 7'h20, 7'h00});
        wait_tick();
        capture(FR);
        chk_segs("t4b", {7'h4F, 7'h06, 7'h24, 7'h0F},
                        {7'h4F, 7'h06, 7'h24, 7'h0F});

        send(16'hABEF, 4'b0100);
        wait_tick();
        capture(FR);
        chk_segs("t5", {7'h08, 7'h60, 7'h30, 7'h38},
                       {7'h08, 7'h60, 7'h30, 7'h38});
        chk("t5_dp0", 32'(dpc[0]), 32'd0);
        chk("t5_dp1", 32'(dpc[1]), 32'd0);
        chk("t5_dp2", 32'(dpc[2]), 32'd6);
        chk("t5_dp3", 32'(dpc[3]), 32'd0);
        chk("t5_stray", 32'(stray), 32'd0);

        wait_tick();
        repeat (4) @(posedge clk);
        #2 blank_en = 1'b1;
        @(negedge clk);
        chk("t6_blank_pre", 32'(dig_sel), 32'hE);
        @(negedge clk);
        chk("t6_blank_now", 32'(dig_sel), 32'hF);
        repeat (10) @(posedge clk);
        #2 blank_en = 1'b0;
        repeat (20) @(negedge clk);

        wait_tick();
        send(16'h00E0, 4'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_dig", 32'(dig_sel), 32'hF);
        chk("t6_rst_seg", 32'(seg), 32'h7F);
        chk("t6_rst_dp", 32'(seg_dp), 32'h1);
        chk("t6_rst_ready", 32'(upd_ready), 32'h1);
        chk("t6_rst_nldig", 32'(dig_sel_nl), 32'hF);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("t6_pend_drop", 32'(upd_ready), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_restart_idx0", 32'(dig_sel), 32'hE);
        wait_tick();
        capture(FR);
        chk_segs("t6", {7'h7F, 7'h7F, 7'h7F, 7'h01},
                       {7'h01, 7'h01, 7'h01, 7'h01});

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
